// File: rtl/z80_bus_arbiter.sv
// Memory-port arbiter between a Z80 core and a DMA requester; the core is frozen while the DMA owns
// the port. Optional burst/CPU-share fairness counters are built when Z80ARB_FAIRNESS_EN is defined.
module z80_bus_arbiter #(
  parameter int unsigned DMA_MAX = 16,
  parameter int unsigned CPU_MIN = 4
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic [15:0] CPU_A,
  input  logic [7:0]  CPU_DO,
  input  logic        CPU_W,
  output logic [7:0]  CPU_DI,
  output logic        HOLD,
  input  logic        DMA_REQ,
  input  logic [15:0] DMA_A,
  input  logic [7:0]  DMA_DO,
  input  logic        DMA_W,
  output logic        DMA_GNT,
  output logic [7:0]  DMA_DI,
  output logic        DMA_VALID,
  output logic [15:0] MEM_A,
  output logic [7:0]  MEM_DO,
  output logic        MEM_W,
  input  logic [7:0]  MEM_DI
);

  typedef enum logic [1:0] {
    S_CPU    = 2'd0,
    S_DMA    = 2'd1,
    S_RESUME = 2'd2
  } state_e;

  state_e state_q;
  logic   hold_q;
  logic   gnt_q;
  logic   valid_q;
  logic   take_ok;
  logic   burst_done;

`ifdef Z80ARB_FAIRNESS_EN
  logic [7:0] burst_q;
  logic [7:0] cpu_cnt_q;
  logic [8:0] burst_next;
  logic [8:0] cpu_next;

  // Counts include the current cycle, so the limits land on the Nth access / Nth core cycle.
  assign burst_next = {1'b0, burst_q} + 9'd1;
  assign cpu_next   = {1'b0, cpu_cnt_q} + 9'd1;
  assign take_ok    = {23'd0, cpu_next} >= CPU_MIN;
  assign burst_done = {23'd0, burst_next} >= DMA_MAX;
`else
  logic unused_params;

  assign unused_params = ^{DMA_MAX[0], CPU_MIN[0]};
  assign take_ok       = 1'b1;
  assign burst_done    = 1'b0;
`endif

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q   <= S_RESUME;
      hold_q    <= 1'b0;
      gnt_q     <= 1'b0;
      valid_q   <= 1'b0;
`ifdef Z80ARB_FAIRNESS_EN
      burst_q   <= 8'd0;
      cpu_cnt_q <= 8'd0;
`endif
    end else begin
      valid_q <= (state_q == S_DMA) && DMA_REQ && !DMA_W;
      case (state_q)
        S_CPU: begin
          // Never steal the port while the core is writing.
          if (DMA_REQ && !CPU_W && take_ok) begin
            state_q <= S_DMA;
            hold_q  <= 1'b0;
            gnt_q   <= 1'b1;
`ifdef Z80ARB_FAIRNESS_EN
            burst_q <= 8'd0;
`endif
          end else begin
`ifdef Z80ARB_FAIRNESS_EN
            cpu_cnt_q <= cpu_next[8] ? 8'hff : cpu_next[7:0];
`endif
          end
        end
        S_DMA: begin
          if (!DMA_REQ || burst_done) begin
            state_q <= S_RESUME;
            hold_q  <= 1'b0;
            gnt_q   <= 1'b0;
          end else begin
`ifdef Z80ARB_FAIRNESS_EN
            burst_q <= burst_next[7:0];
`endif
          end
        end
        S_RESUME: begin
          state_q   <= S_CPU;
          hold_q    <= 1'b1;
          gnt_q     <= 1'b0;
`ifdef Z80ARB_FAIRNESS_EN
          cpu_cnt_q <= 8'd0;
`endif
        end
        default: begin
          state_q <= S_RESUME;
          hold_q  <= 1'b0;
          gnt_q   <= 1'b0;
        end
      endcase
    end
  end

  // S_RESUME re-presents the frozen core's address so its pending read data arrives in time.
  always_comb begin
    MEM_A  = CPU_A;
    MEM_DO = CPU_DO;
    MEM_W  = 1'b0;
    case (state_q)
      S_CPU: MEM_W = CPU_W;
      S_DMA: begin
        MEM_A  = DMA_A;
        MEM_DO = DMA_DO;
        MEM_W  = DMA_W & DMA_REQ;
      end
      default: MEM_W = 1'b0;
    endcase
    if (RESET) begin
      MEM_W = 1'b0;
    end
  end

  assign HOLD      = hold_q;
  assign DMA_GNT   = gnt_q;
  assign DMA_VALID = valid_q;
  assign CPU_DI    = MEM_DI;
  assign DMA_DI    = MEM_DI;

endmodule

// File: tb/tb_z80_bus_arbiter.sv
// Directed bench for z80_bus_arbiter with a 64 KiB memory model; the fairness scenario is selected
// by Z80ARB_FAIRNESS_EN to match the build.
module tb_z80_bus_arbiter;

  logic        clock;
  logic        reset;
  logic [15:0] cpu_a;
  logic [7:0]  cpu_do;
  logic        cpu_w;
  logic [7:0]  cpu_di;
  logic        hold;
  logic        dma_req;
  logic [15:0] dma_a;
  logic [7:0]  dma_do;
  logic        dma_w;
  logic        dma_gnt;
  logic [7:0]  dma_di;
  logic        dma_valid;
  logic [15:0] mem_a;
  logic [7:0]  mem_do;
  logic        mem_w;
  logic [7:0]  mem_di;

  int n_checks = 0;
  int n_fail   = 0;

  z80_bus_arbiter #(
    .DMA_MAX(16),
    .CPU_MIN(4)
  ) dut (
    .CLOCK    (clock),
    .RESET    (reset),
    .CPU_A    (cpu_a),
    .CPU_DO   (cpu_do),
    .CPU_W    (cpu_w),
    .CPU_DI   (cpu_di),
    .HOLD     (hold),
    .DMA_REQ  (dma_req),
    .DMA_A    (dma_a),
    .DMA_DO   (dma_do),
    .DMA_W    (dma_w),
    .DMA_GNT  (dma_gnt),
    .DMA_DI   (dma_di),
    .DMA_VALID(dma_valid),
    .MEM_A    (mem_a),
    .MEM_DO   (mem_do),
    .MEM_W    (mem_w),
    .MEM_DI   (mem_di)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Unwritten locations read back a fixed address-derived pattern.
  logic [7:0] mem [0:65535];
  bit         written [0:65535];
  int         wr_2000 = 0;

  function automatic logic [7:0] pat(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5a;
  endfunction

  always @(posedge clock) begin
    if (mem_w) begin
      mem[mem_a]     <= mem_do;
      written[mem_a] <= 1'b1;
      if (mem_a == 16'h2000) wr_2000 <= wr_2000 + 1;
    end
    mem_di <= written[mem_a] ? mem[mem_a] : pat(mem_a);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic [7:0] exp_rd [3] = '{8'h1a, 8'h1b, 8'h18};

  initial begin
    int acc_cnt;
    int val_cnt;
    int g_cnt;
    int h_cnt;

    reset   = 1'b1;
    cpu_a   = 16'h0000;
    cpu_do  = 8'h00;
    cpu_w   = 1'b1;
    dma_req = 1'b0;
    dma_a   = 16'h0000;
    dma_do  = 8'h00;
    dma_w   = 1'b0;
    #1;
    check_eq("rst_memw", 32'(mem_w), 0);
    tick();
    check_eq("rst_hold", 32'(hold), 0);
    check_eq("rst_gnt", 32'(dma_gnt), 0);
    check_eq("rst_valid", 32'(dma_valid), 0);

    // Reset release: one S_RESUME cycle, then the core runs.
    reset = 1'b0;
    cpu_w = 1'b0;
    #1;
    check_eq("rel_hold0", 32'(hold), 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      cpu_a = 16'h0100 + 16'(i);
      #1;
      check_eq("run_hold", 32'(hold), 1);
      check_eq("run_mema", 32'(mem_a), 32'(16'h0100 + 16'(i)));
    end

    // Three DMA reads at 0x4000..0x4002.
    cpu_a   = 16'h1234;
    dma_req = 1'b1;
    dma_a   = 16'h4000;
    tick();
    check_eq("take_gnt", 32'(dma_gnt), 1);
    check_eq("take_hold", 32'(hold), 0);
    acc_cnt = 0;
    val_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      dma_a = 16'h4000 + 16'(k);
      #1;
      check_eq("dma_mema", 32'(mem_a), 32'(16'h4000 + 16'(k)));
      if (dma_gnt && dma_req) acc_cnt++;
      tick();
      if (dma_valid) val_cnt++;
      check_eq("dma_rdata", 32'(dma_di), 32'(exp_rd[k]));
    end
    check_eq("dma_acc", 32'(acc_cnt), 3);
    check_eq("dma_vcnt", 32'(val_cnt), 3);
    dma_req = 1'b0;
    tick();
    check_eq("res_gnt", 32'(dma_gnt), 0);
    check_eq("res_hold", 32'(hold), 0);
    check_eq("res_valid", 32'(dma_valid), 0);
    check_eq("res_mema", 32'(mem_a), 32'h1234);
    tick();
    check_eq("ret_hold", 32'(hold), 1);

    // Request during a core write must wait for the write to finish.
    for (int i = 0; i < 4; i++) tick();
    cpu_a   = 16'h2000;
    cpu_do  = 8'h77;
    cpu_w   = 1'b1;
    dma_req = 1'b1;
    dma_a   = 16'h2000;
    #1;
    check_eq("cw_memw", 32'(mem_w), 1);
    tick();
    check_eq("cw_nogrant", 32'(dma_gnt), 0);
    check_eq("cw_hold", 32'(hold), 1);
    cpu_w = 1'b0;
    cpu_a = 16'h2001;
    tick();
    check_eq("cw_grant", 32'(dma_gnt), 1);
    tick();
    check_eq("cw_valid", 32'(dma_valid), 1);
    check_eq("cw_rdata", 32'(dma_di), 32'h77);
    dma_req = 1'b0;
    tick();
    tick();
    check_eq("cw_hold2", 32'(hold), 1);
    check_eq("cw_wrcnt", 32'(wr_2000), 1);

    // Reset pulsed mid-burst.
    for (int i = 0; i < 4; i++) tick();
    dma_req = 1'b1;
    dma_a   = 16'h4000;
    tick();
    tick();
    check_eq("mb_valid", 32'(dma_valid), 1);
    reset  = 1'b1;
    dma_w  = 1'b1;
    dma_do = 8'hee;
    dma_a  = 16'h4001;
    #1;
    check_eq("mb_memw", 32'(mem_w), 0);
    tick();
    check_eq("mb_gnt", 32'(dma_gnt), 0);
    check_eq("mb_valid0", 32'(dma_valid), 0);
    check_eq("mb_hold", 32'(hold), 0);
    reset   = 1'b0;
    dma_req = 1'b0;
    dma_w   = 1'b0;
    tick();
    cpu_a = 16'h0abc;
    #1;
    check_eq("mb_hold1", 32'(hold), 1);
    check_eq("mb_mema", 32'(mem_a), 32'h0abc);
    check_eq("mb_nowr", 32'(written[16'h4001]), 0);

`ifdef Z80ARB_FAIRNESS_EN
    // Held request: 16 grant cycles, one resume cycle, 4 core cycles, repeat.
    for (int i = 0; i < 4; i++) tick();
    dma_req = 1'b1;
    tick();
    g_cnt = 0;
    while (dma_gnt && g_cnt < 40) begin
      g_cnt++;
      tick();
    end
    check_eq("fair_gnt", 32'(g_cnt), 16);
    check_eq("fair_res", 32'({hold, dma_gnt}), 0);
    tick();
    h_cnt = 0;
    while (hold && h_cnt < 40) begin
      h_cnt++;
      tick();
    end
    check_eq("fair_hold", 32'(h_cnt), 4);
    check_eq("fair_regnt", 32'(dma_gnt), 1);
    dma_req = 1'b0;
    tick();
    tick();
`else
    // Held request: continuous grant, core stays frozen.
    dma_req = 1'b1;
    g_cnt   = 0;
    h_cnt   = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (dma_gnt) g_cnt++;
      if (hold) h_cnt++;
    end
    check_eq("long_gnt", 32'(g_cnt), 40);
    check_eq("long_hold", 32'(h_cnt), 0);
    dma_req = 1'b0;
    tick();
    check_eq("long_res", 32'(dma_gnt), 0);
    tick();
    check_eq("long_ret", 32'(hold), 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
